alpha_gc_extract: RTL and testbench

- Parametrised successor to the fixed 2-bit alpha path in ddr_data.
- Consumes DDR read-back words of per-gate random symbols (consecutive gates, starting at a programmed base gate count) and an ascending stream of detection gate counts (dq_gc).
- For each gate count, seeks the matching DDR word, extracts the symbol at that gate and packs symbols into OUT_W-bit words for the alpha stream to xdma.
- Sits between the DDR read FIFO and the alpha FIFO.

---
 rtl/alpha_gc_extract.sv | 206 ++++++++++++++++++++
 tb/tb_alpha_gc_extract.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alpha_gc_extract.sv
`default_nettype none
// ============================================================================
// Module   : alpha_gc_extract
// Brief    : Seeks DDR read-back words by detection gate count, extracts the
//            per-gate symbol and packs symbols into OUT_W-bit alpha words.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module alpha_gc_extract #(
    parameter int SYM_W  = 2,
    parameter int WORD_W = 256,
    parameter int OUT_W  = 128,
    parameter int GC_W   = 48
) (
    input  logic              clk200_i,
    input  logic              alpha_rst,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              flush_i,
    input  logic [GC_W-1:0]   gc_base_i,
    input  logic [WORD_W-1:0] s_axis_word_tdata,
    input  logic              s_axis_word_tvalid,
    output logic              s_axis_word_tready,
    input  logic [GC_W-1:0]   s_axis_gc_tdata,
    input  logic              s_axis_gc_tvalid,
    output logic              s_axis_gc_tready,
    output logic [OUT_W-1:0]  m_axis_alpha_tdata,
    output logic              m_axis_alpha_tvalid,
    input  logic              m_axis_alpha_tready,
    output logic              m_axis_alpha_tlast,
    output logic [31:0]       gc_count,
    output logic [31:0]       word_count,
    output logic              err_order
);

    localparam int SPW    = WORD_W / SYM_W;
    localparam int SPO    = OUT_W / SYM_W;
    localparam int SPW_LG = $clog2(SPW);
    localparam int SYM_LG = $clog2(SYM_W);
    localparam int CNT_W  = $clog2(SPO) + 1;
    localparam int RIDX_W = $clog2(WORD_W);
    localparam int WIDX_W = $clog2(OUT_W);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_GC = 3'd1,
        S_SEEK    = 3'd2,
        S_EXTRACT = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    state_t             r_state;
    logic [GC_W-1:0]    r_base;
    logic [GC_W-1:0]    r_cur_idx;
    logic [GC_W-1:0]    r_tgt;
    logic [SPW_LG-1:0]  r_off;
    logic               r_word_valid;
    logic [WORD_W-1:0]  r_word;
    logic [OUT_W-1:0]   r_pack;
    logic [CNT_W-1:0]   r_pack_cnt;
    logic               r_tvalid;
    logic               r_tlast;
    logic               r_stop_pend;
    logic               r_err;
    logic [31:0]        r_gc_cnt;
    logic [31:0]        r_word_cnt;

    logic               w_pack_nz;
    logic               w_seek_hit;
    logic [GC_W-1:0]    w_rel;
    logic [GC_W-1:0]    w_tgt;
    logic [SPW_LG-1:0]  w_off;
    logic               w_drop;
    logic [RIDX_W-1:0]  w_rd_idx;
    logic [WIDX_W-1:0]  w_wr_idx;
    logic [SYM_W-1:0]   w_sym;

    assign w_pack_nz  = (r_pack_cnt != '0);
    assign w_seek_hit = r_word_valid && (r_cur_idx == r_tgt);

    // Readies are withheld whenever the cycle is claimed by stop or flush so
    // that upstream never sees a handshake the block does not act on.
    assign s_axis_gc_tready   = (r_state == S_WAIT_GC) && !stop_i && !(flush_i && w_pack_nz);
    assign s_axis_word_tready = (r_state == S_SEEK) && !w_seek_hit && !stop_i;

    assign w_rel  = s_axis_gc_tdata - r_base;
    assign w_tgt  = w_rel >> SPW_LG;
    assign w_off  = w_rel[SPW_LG-1:0];
    assign w_drop = (s_axis_gc_tdata < r_base) || (r_word_valid && (w_tgt < r_cur_idx));

    assign w_rd_idx = RIDX_W'(r_off) << SYM_LG;
    assign w_wr_idx = WIDX_W'(r_pack_cnt) << SYM_LG;
    assign w_sym    = r_word[w_rd_idx +: SYM_W];

    assign m_axis_alpha_tdata  = r_pack;
    assign m_axis_alpha_tvalid = r_tvalid;
    assign m_axis_alpha_tlast  = r_tlast;
    assign gc_count            = r_gc_cnt;
    assign word_count          = r_word_cnt;
    assign err_order           = r_err;

    always_ff @(posedge clk200_i or posedge alpha_rst) begin
        if (alpha_rst) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_cur_idx    <= '0;
            r_tgt        <= '0;
            r_off        <= '0;
            r_word_valid <= 1'b0;
            r_word       <= '0;
            r_pack       <= '0;
            r_pack_cnt   <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_err        <= 1'b0;
            r_gc_cnt     <= '0;
            r_word_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_base       <= gc_base_i;
                        r_word_valid <= 1'b0;
                        r_cur_idx    <= '0;
                        r_pack       <= '0;
                        r_pack_cnt   <= '0;
                        r_gc_cnt     <= '0;
                        r_word_cnt   <= '0;
                        r_err        <= 1'b0;
                        r_stop_pend  <= 1'b0;
                        r_tlast      <= 1'b0;
                        r_state      <= S_WAIT_GC;
                    end
                end
                S_WAIT_GC: begin
                    if (stop_i) begin
                        r_pack     <= '0;
                        r_pack_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else if (flush_i && w_pack_nz) begin
                        r_tvalid <= 1'b1;
                        r_tlast  <= 1'b1;
                        r_state  <= S_OUT;
                    end else if (s_axis_gc_tvalid) begin
                        if (w_drop) begin
                            r_err <= 1'b1;
                        end else begin
                            r_gc_cnt <= r_gc_cnt + 32'd1;
                            r_tgt    <= w_tgt;
                            r_off    <= w_off;
                            r_state  <= S_SEEK;
                        end
                    end
                end
                S_SEEK: begin
                    if (stop_i) begin
                        r_pack     <= '0;
                        r_pack_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else if (w_seek_hit) begin
                        r_state <= S_EXTRACT;
                    end else if (s_axis_word_tvalid) begin
                        // The first word after start is index 0; later ones advance.
                        r_word       <= s_axis_word_tdata;
                        r_word_cnt   <= r_word_cnt + 32'd1;
                        r_cur_idx    <= r_word_valid ? (r_cur_idx + 1'b1) : '0;
                        r_word_valid <= 1'b1;
                    end
                end
                S_EXTRACT: begin
                    if (stop_i) begin
                        r_pack     <= '0;
                        r_pack_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_pack[w_wr_idx +: SYM_W] <= w_sym;
                        r_pack_cnt                <= r_pack_cnt + 1'b1;
                        if (r_pack_cnt == CNT_W'(SPO - 1)) begin
                            r_tvalid <= 1'b1;
                            r_tlast  <= 1'b0;
                            r_state  <= S_OUT;
                        end else begin
                            r_state <= S_WAIT_GC;
                        end
                    end
                end
                S_OUT: begin
                    if (stop_i) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (m_axis_alpha_tready) begin
                        r_tvalid    <= 1'b0;
                        r_tlast     <= 1'b0;
                        r_pack      <= '0;
                        r_pack_cnt  <= '0;
                        r_stop_pend <= 1'b0;
                        r_state     <= (r_stop_pend || stop_i) ? S_IDLE : S_WAIT_GC;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alpha_gc_extract.sv
`default_nettype none
// ============================================================================
// Module   : tb_alpha_gc_extract
// Brief    : Directed and randomized bench for alpha_gc_extract against a
//            gate-count level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alpha_gc_extract;

    localparam int SYM_W  = 2;
    localparam int WORD_W = 256;
    localparam int OUT_W  = 128;
    localparam int GC_W   = 48;
    localparam int SPW    = WORD_W / SYM_W;
    localparam int SPO    = OUT_W / SYM_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0, stop_i = 1'b0, flush_i = 1'b0;
    logic [GC_W-1:0]   gc_base_i = '0;
    logic [WORD_W-1:0] word_tdata = '0;
    logic              word_tvalid = 1'b0, word_tready;
    logic [GC_W-1:0]   gc_tdata = '0;
    logic              gc_tvalid = 1'b0, gc_tready;
    logic [OUT_W-1:0]  out_tdata;
    logic              out_tvalid, out_tlast;
    logic              out_tready = 1'b0;
    logic [31:0]       gc_cnt, word_cnt;
    logic              err;

    always #5 clk = ~clk;

    alpha_gc_extract #(.SYM_W(SYM_W), .WORD_W(WORD_W), .OUT_W(OUT_W), .GC_W(GC_W)) dut (
        .clk200_i(clk), .alpha_rst(rst), .start_i(start_i), .stop_i(stop_i), .flush_i(flush_i),
        .gc_base_i(gc_base_i),
        .s_axis_word_tdata(word_tdata), .s_axis_word_tvalid(word_tvalid), .s_axis_word_tready(word_tready),
        .s_axis_gc_tdata(gc_tdata), .s_axis_gc_tvalid(gc_tvalid), .s_axis_gc_tready(gc_tready),
        .m_axis_alpha_tdata(out_tdata), .m_axis_alpha_tvalid(out_tvalid),
        .m_axis_alpha_tready(out_tready), .m_axis_alpha_tlast(out_tlast),
        .gc_count(gc_cnt), .word_count(word_cnt), .err_order(err)
    );

    typedef struct { logic [OUT_W-1:0] d; logic l; } out_t;

    int                errors = 0;
    int                checks = 0;
    logic [WORD_W-1:0] words [16];
    int                nwords, widx;
    bit                word_en, gc_en;
    logic [GC_W-1:0]   gcq [$];
    out_t              exp_q [$];
    logic [OUT_W-1:0]  last_d;
    logic              last_l;

    // Reference model state: what the alpha stream should contain.
    logic [GC_W-1:0]   m_base;
    bit                m_any;
    longint unsigned   m_tgt;
    logic [OUT_W-1:0]  m_pack;
    int                m_cnt;
    int                m_gc;
    bit                m_err;

    task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] rand_word();
        logic [WORD_W-1:0] w;
        for (int i = 0; i < WORD_W / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    function automatic void model_push(input bit last);
        out_t o;
        o.d = m_pack;
        o.l = last;
        exp_q.push_back(o);
        m_pack = '0;
        m_cnt  = 0;
    endfunction

    function automatic void model_gc(input logic [GC_W-1:0] gc);
        longint unsigned rel, tgt, off;
        logic [WORD_W-1:0] w;
        if (gc < m_base) begin m_err = 1; return; end
        rel = longint'(gc - m_base);
        tgt = rel / SPW;
        off = rel % SPW;
        if (m_any && tgt < m_tgt) begin m_err = 1; return; end
        m_any = 1;
        m_tgt = tgt;
        m_gc++;
        w = words[int'(tgt)];
        m_pack[m_cnt*SYM_W +: SYM_W] = w[int'(off)*SYM_W +: SYM_W];
        m_cnt++;
        if (m_cnt == SPO) model_push(1'b0);
    endfunction

    function automatic void drive_feeds();
        word_tvalid = word_en && (widx < nwords);
        word_tdata  = (widx < nwords) ? words[widx] : '0;
        gc_tvalid   = gc_en && (gcq.size() > 0);
        gc_tdata    = (gcq.size() > 0) ? gcq[0] : '0;
    endfunction

    // One clock cycle: detect handshakes before the edge, update feeds after it.
    task automatic tick();
        bit hw, hg, ho;
        out_t e;
        drive_feeds();
        #1;
        hw = word_tvalid && word_tready;
        hg = gc_tvalid && gc_tready;
        ho = out_tvalid && out_tready;
        if (ho) begin
            last_d = out_tdata;
            last_l = out_tlast;
            chk("out_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_data", out_tdata, e.d);
                chk("out_last", out_tlast, e.l);
            end
        end
        if (hg) model_gc(gcq[0]);
        @(posedge clk);
        #1;
        if (hw) widx++;
        if (hg) void'(gcq.pop_front());
        @(negedge clk);
    endtask

    task automatic begin_run(input logic [GC_W-1:0] base, input bit do_rst);
        if (do_rst) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
        end
        gcq.delete();
        exp_q.delete();
        widx = 0;
        word_en = 1; gc_en = 1; out_tready = 1'b1;
        m_base = base; m_any = 0; m_tgt = 0; m_pack = '0; m_cnt = 0; m_gc = 0; m_err = 0;
        gc_base_i = base;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit done = 0;
        for (int i = 0; i < 4000 && !done; i++) begin
            if (gcq.size() == 0 && gc_tready && !out_tvalid) done = 1;
            else tick();
        end
        chk({tag, "_drain"}, done, 1);
    endtask

    task automatic do_flush(input string tag);
        flush_i = 1'b1;
        if (m_cnt > 0) model_push(1'b1);
        tick();
        flush_i = 1'b0;
        drain(tag);
    endtask

    task automatic wait_tvalid(input string tag);
        bit done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            if (out_tvalid) done = 1;
            else tick();
        end
        chk({tag, "_tvalid"}, done, 1);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_gc_count"}, gc_cnt, 32'(m_gc));
        chk({tag, "_word_count"}, word_cnt, m_any ? 32'(m_tgt + 1) : 32'd0);
        chk({tag, "_err_order"}, err, m_err);
        chk({tag, "_no_leftover"}, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OUT_W-1:0] hold;
        int rel;

        nwords = 0; widx = 0; word_en = 0; gc_en = 0;
        @(negedge clk);
        #1;
        chk("rst_tvalid", out_tvalid, 0);
        chk("rst_tdata", out_tdata, 0);
        chk("rst_tlast", out_tlast, 0);
        chk("rst_gc_count", gc_cnt, 0);
        chk("rst_word_count", word_cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_gc_tready", gc_tready, 0);
        chk("rst_word_tready", word_tready, 0);
        @(negedge clk);

        // Full pack from a single word whose symbol k is k mod 4.
        words[0] = {32{8'hE4}};
        words[1] = rand_word();
        nwords = 2;
        begin_run(48'h1000, 1);
        for (int i = 0; i < 64; i++) gcq.push_back(48'h1000 + 48'(i));
        drain("t1");
        chk("t1_pattern", last_d, {16{8'hE4}});
        chk("t1_tlast", last_l, 0);
        chk("t1_word_count_lit", word_cnt, 1);
        chk("t1_gc_count_lit", gc_cnt, 64);
        chk_counts("t1");

        // Seek past W0 into W1.
        words[0] = rand_word();
        words[1] = rand_word();
        words[1][3:2] = 2'b11;
        begin_run(48'h1000, 1);
        gcq.push_back(48'h1000);
        gcq.push_back(48'h1081);
        for (int i = 0; i < 62; i++) gcq.push_back(48'h1082 + 48'(i));
        drain("t2");
        chk("t2_slot1", last_d[3:2], 2'b11);
        chk("t2_word_count_lit", word_cnt, 2);
        chk_counts("t2");

        // Out-of-order and below-base gate counts are dropped.
        words[0] = rand_word();
        words[1] = rand_word();
        begin_run(48'h1000, 1);
        gcq.push_back(48'h0FFF);
        gcq.push_back(48'h1000);
        gcq.push_back(48'h1080);
        gcq.push_back(48'h1005);
        drain("t3");
        chk("t3_err_lit", err, 1);
        chk("t3_gc_count_lit", gc_cnt, 2);
        do_flush("t3f");
        chk_counts("t3");

        // Partial pack flushed, then a second short pack starting from slot 0.
        begin_run(48'h1000, 1);
        gcq.push_back(48'h1000); gcq.push_back(48'h1003); gcq.push_back(48'h1003);
        gcq.push_back(48'h1010); gcq.push_back(48'h107F);
        drain("t4");
        do_flush("t4f");
        chk("t4_tlast", last_l, 1);
        chk("t4_upper_zero", last_d >> 10, 0);
        gcq.push_back(48'h1080); gcq.push_back(48'h1081);
        drain("t4b");
        do_flush("t4bf");
        chk("t4b_upper_zero", last_d >> 4, 0);
        chk_counts("t4");

        // Backpressure on a full pack.
        words[0] = rand_word();
        words[1] = rand_word();
        begin_run(48'h1000, 1);
        out_tready = 1'b0;
        rel = 0;
        for (int i = 0; i < 65; i++) begin
            rel += $urandom_range(0, 3);
            if (rel > 255) rel = 255;
            gcq.push_back(48'h1000 + 48'(rel));
        end
        wait_tvalid("t5");
        hold = out_tdata;
        for (int i = 0; i < 50; i++) begin
            chk("t5_hold_tvalid", out_tvalid, 1);
            chk("t5_hold_tdata", out_tdata, hold);
            chk("t5_gc_blocked", gc_tready, 0);
            tick();
        end
        out_tready = 1'b1;
        tick();
        chk("t5_single_hs", out_tvalid, 0);
        drain("t5");
        do_flush("t5f");
        chk_counts("t5");

        // Stop while seeking, then restart with a new base.
        begin_run(48'h1000, 1);
        word_en = 0;
        gcq.push_back(48'h0FFF);
        gcq.push_back(48'h1000);
        for (int i = 0; i < 6; i++) tick();
        chk("t6_err_before", err, 1);
        chk("t6_gc_before", gc_cnt, 1);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        chk("t6_idle_gc_tready", gc_tready, 0);
        chk("t6_idle_word_tready", word_tready, 0);
        chk("t6_idle_tvalid", out_tvalid, 0);
        for (int i = 0; i < 8; i++) words[i] = rand_word();
        nwords = 8;
        begin_run(48'h2000, 0);
        chk("t6_gc_cleared", gc_cnt, 0);
        chk("t6_word_cleared", word_cnt, 0);
        chk("t6_err_cleared", err, 0);

        // Randomized ascending stream with occasional stale gate counts.
        rel = 0;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0 && rel >= SPW)
                gcq.push_back(48'h2000 + 48'($urandom_range(0, (rel / SPW) * SPW - 1)));
            else begin
                rel += $urandom_range(0, 12);
                if (rel > 8 * SPW - 1) rel = 8 * SPW - 1;
                gcq.push_back(48'h2000 + 48'(rel));
            end
        end
        drain("t7");
        do_flush("t7f");
        chk_counts("t7");

        // Asynchronous reset while a full pack waits for the consumer.
        begin_run(48'h3000, 1);
        out_tready = 1'b0;
        for (int i = 0; i < 64; i++) gcq.push_back(48'h3000 + 48'(i));
        wait_tvalid("t8");
        #2;
        rst = 1'b1;
        #1;
        chk("t8_rst_tvalid", out_tvalid, 0);
        chk("t8_rst_tdata", out_tdata, 0);
        chk("t8_rst_gc_count", gc_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
